// File: rtl/spi_responder_if.sv
// spi_responder_if
//   Bundles the SPI pins and the local tx/rx handshakes of spi_responder.
//   Parameter n: frame width in bits.
//   slave modport  : the responder's view (pins and tx word in; miso, rx word,
//                    handshake pulses and status out).
//   master modport : the view of whatever drives the responder (SPI controller
//                    plus local producer/consumer).
//   Signals:
//     ss_n        active-low select
//     mosi        serial data in, MSB first
//     miso        serial data out, MSB first
//     tx_data     word to transmit
//     tx_valid    tx_data is offered
//     tx_ready    one-cycle pulse, offered word was taken
//     rx_data     last completed received word
//     rx_valid    one-cycle pulse, rx_data updated
//     busy        responder is not idle
//     frame_err   one-cycle pulse, select rose mid-word
//     tx_underrun one-cycle pulse, fill word loaded
interface spi_responder_if #(
  parameter int n = 8
);
  logic         ss_n;
  logic         mosi;
  logic         miso;
  logic [n-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [n-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         frame_err;
  logic         tx_underrun;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
  );
endinterface

// File: rtl/spi_responder.sv
// spi_responder
//   SPI target: shifts a frame in on mosi while shifting the loaded tx word
//   out on miso, framed by the active-low select. Everything runs on the
//   rising edge of sclk.
//   Parameters: n (frame width, n >= 2), FILL (word sent when no tx word is
//   offered at a load point).
//   Ports:
//     sclk     SPI clock
//     n_reset  asynchronous, active-low reset
//     bus      spi_responder_if.slave (pins, tx/rx handshakes, status)
//   Build option: define SPI_RESPONDER_TRISTATE_EN to float miso while
//   deselected or in reset, so several responders can share one line.
module spi_responder #(
  parameter int           n    = 8,
  parameter logic [n-1:0] FILL = {n{1'b1}}
) (
  input  logic              sclk,
  input  logic              n_reset,
  spi_responder_if.slave    bus
);

  localparam int               CNT_W = $clog2(n);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(n - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    RELOAD = 2'd2
  } state_t;

  state_t           state;
  logic [n-1:0]     sreg;
  logic [CNT_W-1:0] cnt;
  logic [n-1:0]     shifted;

  assign shifted = {sreg[n-2:0], bus.mosi};

  always_ff @(posedge sclk or negedge n_reset) begin
    if (!n_reset) begin
      state           <= IDLE;
      sreg            <= '0;
      cnt             <= '0;
      bus.rx_data     <= '0;
      bus.rx_valid    <= 1'b0;
      bus.tx_ready    <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.tx_underrun <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all branches see the values from
      // before this edge; the pulse outputs default low and are set for one
      // cycle only by the branch that raises them.
      bus.rx_valid    <= 1'b0;
      bus.tx_ready    <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.tx_underrun <= 1'b0;

      case (state)
        IDLE: begin
          if (!bus.ss_n) begin
            if (bus.tx_valid) begin
              sreg         <= bus.tx_data;
              bus.tx_ready <= 1'b1;
            end else begin
              sreg            <= FILL;
              bus.tx_underrun <= 1'b1;
            end
            cnt   <= '0;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // The last-bit edge completes the word even if select has just
          // risen; RELOAD then returns to IDLE.
          if (cnt == LAST) begin
            sreg         <= shifted;
            bus.rx_data  <= shifted;
            bus.rx_valid <= 1'b1;
            state        <= RELOAD;
          end else if (!bus.ss_n) begin
            sreg <= shifted;
            cnt  <= cnt + 1'b1;
          end else begin
            cnt           <= '0;
            bus.frame_err <= 1'b1;
            state         <= IDLE;
          end
        end

        RELOAD: begin
          if (!bus.ss_n) begin
            if (bus.tx_valid) begin
              sreg         <= bus.tx_data;
              bus.tx_ready <= 1'b1;
            end else begin
              sreg            <= FILL;
              bus.tx_underrun <= 1'b1;
            end
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

`ifdef SPI_RESPONDER_TRISTATE_EN
  assign bus.miso = (!n_reset || bus.ss_n) ? 1'bz : sreg[n-1];
`else
  assign bus.miso = bus.ss_n ? 1'b0 : sreg[n-1];
`endif

endmodule
